// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter for the register bank write port: requester 0 is unbuffered with priority,
// requester 1 is queued in a FIFO whose head is forced through after STARVE_LIMIT lost cycles.
module reg_wb_arbiter #(
    parameter int unsigned W            = 32,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     r0_valid,
    input  logic [4:0]               r0_addr,
    input  logic [W-1:0]             r0_data,
    output logic                     r0_ready,
    input  logic                     r1_valid,
    input  logic [4:0]               r1_addr,
    input  logic [W-1:0]             r1_data,
    output logic                     r1_ready,
    output logic                     RegWrite,
    output logic [4:0]               write_reg_in,
    output logic [W-1:0]             write_data_in,
    output logic [31:0]              busy_mask,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    mem_addr [DEPTH];
    logic [W-1:0]  mem_data [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [SW-1:0] wait_q;
    logic          reg_write_q;
    logic [4:0]    write_reg_q;
    logic [W-1:0]  write_data_q;

    logic          qne, starve, grant0, pop, push, not_full;
    logic [4:0]    head_addr;
    logic [W-1:0]  head_data;

    always_comb begin
        qne       = (count_q != '0);
        starve    = qne && (wait_q == SW'(STARVE_LIMIT));
        grant0    = r0_valid && !starve;
        pop       = qne && (starve || !r0_valid);
        // Readiness ignores a same-cycle pop: no pass-through when full.
        not_full  = (count_q < CW'(DEPTH));
        push      = r1_valid && not_full;
        head_addr = mem_addr[rd_ptr_q];
        head_data = mem_data[rd_ptr_q];
    end

    assign r0_ready      = !starve;
    assign r1_ready      = not_full;
    assign RegWrite      = reg_write_q;
    assign write_reg_in  = write_reg_q;
    assign write_data_in = write_data_q;
    assign q_count       = count_q;

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                busy_mask[mem_addr[rd_ptr_q + AW'(i)]] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= r1_addr;
            mem_data[wr_ptr_q] <= r1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            wait_q       <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);

            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            // Counts lost cycles of the current head; a new head starts from zero.
            if (qne && !pop) begin
                if (wait_q != SW'(STARVE_LIMIT)) wait_q <= wait_q + SW'(1);
            end else begin
                wait_q <= '0;
            end

            if (grant0) begin
                reg_write_q  <= (r0_addr != 5'd0);
                write_reg_q  <= r0_addr;
                write_data_q <= r0_data;
            end else if (pop) begin
                reg_write_q  <= (head_addr != 5'd0);
                write_reg_q  <= head_addr;
                write_data_q <= head_data;
            end else begin
                reg_write_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed self-checking bench for reg_wb_arbiter (W=32, DEPTH=2, STARVE_LIMIT=4).
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r1_valid;
    logic [4:0]  r0_addr, r1_addr;
    logic [31:0] r0_data, r1_data;
    logic        r0_ready, r1_ready;
    logic        RegWrite;
    logic [4:0]  write_reg_in;
    logic [31:0] write_data_in;
    logic [31:0] busy_mask;
    logic [1:0]  q_count;

    int checks = 0;
    int passed = 0;

    reg_wb_arbiter #(.W(32), .DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .r0_valid     (r0_valid),
        .r0_addr      (r0_addr),
        .r0_data      (r0_data),
        .r0_ready     (r0_ready),
        .r1_valid     (r1_valid),
        .r1_addr      (r1_addr),
        .r1_data      (r1_data),
        .r1_ready     (r1_ready),
        .RegWrite     (RegWrite),
        .write_reg_in (write_reg_in),
        .write_data_in(write_data_in),
        .busy_mask    (busy_mask),
        .q_count      (q_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
        r0_addr = '0; r0_data = '0; r1_addr = '0; r1_data = '0;
        step(); step();
        rst = 1'b0;
        #1;
        checks++; if (RegWrite !== 1'b0) $display("FAIL rst_we: got %b want 0", RegWrite); else passed++;
        checks++; if (write_reg_in !== 5'd0) $display("FAIL rst_addr: got %0d want 0", write_reg_in); else passed++;
        checks++; if (write_data_in !== 32'd0) $display("FAIL rst_data: got %h want 0", write_data_in); else passed++;
        checks++; if (q_count !== 2'd0) $display("FAIL rst_qcount: got %0d want 0", q_count); else passed++;
        checks++; if (busy_mask !== 32'd0) $display("FAIL rst_busy: got %h want 0", busy_mask); else passed++;
        checks++; if (r0_ready !== 1'b1) $display("FAIL rst_r0_ready: got %b want 1", r0_ready); else passed++;
        checks++; if (r1_ready !== 1'b1) $display("FAIL rst_r1_ready: got %b want 1", r1_ready); else passed++;
        step();
        checks++; if (RegWrite !== 1'b0) $display("FAIL idle_we: got %b want 0", RegWrite); else passed++;
    endtask

    task automatic test_r0_solo();
        r0_valid = 1'b1; r0_addr = 5'd5; r0_data = 32'hDEADBEEF;
        #1;
        checks++; if (r0_ready !== 1'b1) $display("FAIL r0_solo_ready: got %b want 1", r0_ready); else passed++;
        step();
        r0_valid = 1'b0;
        checks++; if (RegWrite !== 1'b1) $display("FAIL r0_solo_we: got %b want 1", RegWrite); else passed++;
        checks++; if (write_reg_in !== 5'd5) $display("FAIL r0_solo_addr: got %0d want 5", write_reg_in); else passed++;
        checks++; if (write_data_in !== 32'hDEADBEEF) $display("FAIL r0_solo_data: got %h want deadbeef", write_data_in); else passed++;
        step();
        checks++; if (RegWrite !== 1'b0) $display("FAIL r0_solo_we_drop: got %b want 0", RegWrite); else passed++;
        checks++; if (write_reg_in !== 5'd5) $display("FAIL r0_solo_hold: got %0d want 5", write_reg_in); else passed++;
    endtask

    task automatic test_r1_solo();
        r1_valid = 1'b1; r1_addr = 5'd9; r1_data = 32'h12;
        #1;
        checks++; if (r1_ready !== 1'b1) $display("FAIL r1_solo_ready: got %b want 1", r1_ready); else passed++;
        step();
        r1_valid = 1'b0;
        #1;
        checks++; if (q_count !== 2'd1) $display("FAIL r1_solo_qcount: got %0d want 1", q_count); else passed++;
        checks++; if (busy_mask !== 32'h0000_0200) $display("FAIL r1_solo_busy: got %h want 00000200", busy_mask); else passed++;
        checks++; if (RegWrite !== 1'b0) $display("FAIL r1_solo_we_early: got %b want 0", RegWrite); else passed++;
        step();
        checks++; if (RegWrite !== 1'b1) $display("FAIL r1_solo_we: got %b want 1", RegWrite); else passed++;
        checks++; if (write_reg_in !== 5'd9) $display("FAIL r1_solo_addr: got %0d want 9", write_reg_in); else passed++;
        checks++; if (write_data_in !== 32'h12) $display("FAIL r1_solo_data: got %h want 12", write_data_in); else passed++;
        checks++; if (busy_mask !== 32'd0) $display("FAIL r1_solo_busy_clr: got %h want 0", busy_mask); else passed++;
        checks++; if (q_count !== 2'd0) $display("FAIL r1_solo_qempty: got %0d want 0", q_count); else passed++;
        step();
    endtask

    task automatic test_starvation();
        r0_valid = 1'b1; r0_addr = 5'd1; r0_data = 32'h101;
        r1_valid = 1'b1; r1_addr = 5'd7; r1_data = 32'h77;
        #1;
        checks++; if (r0_ready !== 1'b1) $display("FAIL starve_r0_ready0: got %b want 1", r0_ready); else passed++;
        step();
        r1_valid = 1'b0;
        checks++; if (write_reg_in !== 5'd1) $display("FAIL starve_first_r0: got %0d want 1", write_reg_in); else passed++;
        checks++; if (busy_mask !== 32'h0000_0080) $display("FAIL starve_busy: got %h want 00000080", busy_mask); else passed++;
        // Four cycles where the head loses to requester 0.
        for (int k = 0; k < 4; k++) begin
            r0_addr = 5'(10 + k); r0_data = 32'(16'h1000 + k);
            #1;
            checks++; if (r0_ready !== 1'b1) $display("FAIL starve_lose%0d_ready: got %b want 1", k, r0_ready); else passed++;
            step();
            checks++; if (RegWrite !== 1'b1 || write_reg_in !== 5'(10 + k))
                $display("FAIL starve_lose%0d_write: got we=%b addr=%0d want we=1 addr=%0d", k, RegWrite, write_reg_in, 10 + k);
            else passed++;
        end
        r0_addr = 5'd20; r0_data = 32'h2020;
        #1;
        checks++; if (r0_ready !== 1'b0) $display("FAIL starve_forced_ready: got %b want 0", r0_ready); else passed++;
        step();
        checks++; if (RegWrite !== 1'b1 || write_reg_in !== 5'd7 || write_data_in !== 32'h77)
            $display("FAIL starve_head_write: got we=%b addr=%0d data=%h want we=1 addr=7 data=77", RegWrite, write_reg_in, write_data_in);
        else passed++;
        checks++; if (r0_ready !== 1'b1) $display("FAIL starve_ready_back: got %b want 1", r0_ready); else passed++;
        checks++; if (q_count !== 2'd0) $display("FAIL starve_qempty: got %0d want 0", q_count); else passed++;
        step();
        r0_valid = 1'b0;
        checks++; if (write_reg_in !== 5'd20 || write_data_in !== 32'h2020)
            $display("FAIL starve_held_r0: got addr=%0d data=%h want addr=20 data=2020", write_reg_in, write_data_in);
        else passed++;
        step();
    endtask

    task automatic test_fifo_full();
        r0_valid = 1'b1; r0_addr = 5'd11; r0_data = 32'hB;
        r1_valid = 1'b1; r1_addr = 5'd3; r1_data = 32'h33;
        #1;
        checks++; if (r1_ready !== 1'b1) $display("FAIL full_ready_c1: got %b want 1", r1_ready); else passed++;
        step();
        r1_addr = 5'd4; r1_data = 32'h44;
        #1;
        checks++; if (q_count !== 2'd1 || r1_ready !== 1'b1)
            $display("FAIL full_c2: got q=%0d rdy=%b want q=1 rdy=1", q_count, r1_ready);
        else passed++;
        step();
        r1_addr = 5'd6; r1_data = 32'h66;
        #1;
        checks++; if (q_count !== 2'd2) $display("FAIL full_qcount2: got %0d want 2", q_count); else passed++;
        checks++; if (r1_ready !== 1'b0) $display("FAIL full_ready_c3: got %b want 0", r1_ready); else passed++;
        checks++; if (busy_mask !== 32'h0000_0018) $display("FAIL full_busy: got %h want 00000018", busy_mask); else passed++;
        step();
        checks++; if (r1_ready !== 1'b0 || r0_ready !== 1'b1)
            $display("FAIL full_c4: got r1rdy=%b r0rdy=%b want 0 1", r1_ready, r0_ready);
        else passed++;
        step();
        checks++; if (r0_ready !== 1'b1) $display("FAIL full_c5_r0_ready: got %b want 1", r0_ready); else passed++;
        step();
        checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0)
            $display("FAIL full_c6_starve: got r0rdy=%b r1rdy=%b want 0 0", r0_ready, r1_ready);
        else passed++;
        step();
        checks++; if (RegWrite !== 1'b1 || write_reg_in !== 5'd3 || write_data_in !== 32'h33)
            $display("FAIL full_order_3: got we=%b addr=%0d data=%h want 1 3 33", RegWrite, write_reg_in, write_data_in);
        else passed++;
        checks++; if (q_count !== 2'd1 || r1_ready !== 1'b1)
            $display("FAIL full_slot_free: got q=%0d rdy=%b want q=1 rdy=1", q_count, r1_ready);
        else passed++;
        step();
        r0_valid = 1'b0; r1_valid = 1'b0;
        checks++; if (write_reg_in !== 5'd11) $display("FAIL full_r0_between: got %0d want 11", write_reg_in); else passed++;
        checks++; if (q_count !== 2'd2 || busy_mask !== 32'h0000_0050)
            $display("FAIL full_after_push6: got q=%0d busy=%h want q=2 busy=00000050", q_count, busy_mask);
        else passed++;
        step();
        checks++; if (RegWrite !== 1'b1 || write_reg_in !== 5'd4 || write_data_in !== 32'h44)
            $display("FAIL full_order_4: got we=%b addr=%0d data=%h want 1 4 44", RegWrite, write_reg_in, write_data_in);
        else passed++;
        step();
        checks++; if (RegWrite !== 1'b1 || write_reg_in !== 5'd6 || write_data_in !== 32'h66)
            $display("FAIL full_order_6: got we=%b addr=%0d data=%h want 1 6 66", RegWrite, write_reg_in, write_data_in);
        else passed++;
        checks++; if (q_count !== 2'd0) $display("FAIL full_drained: got %0d want 0", q_count); else passed++;
        step();
    endtask

    task automatic test_push_pop();
        r1_valid = 1'b1; r1_addr = 5'd12; r1_data = 32'hC12;
        step();
        r1_addr = 5'd13; r1_data = 32'hC13;
        #1;
        checks++; if (q_count !== 2'd1) $display("FAIL pp_q1: got %0d want 1", q_count); else passed++;
        step();
        r1_valid = 1'b0;
        checks++; if (q_count !== 2'd1) $display("FAIL pp_q_stays1: got %0d want 1", q_count); else passed++;
        checks++; if (RegWrite !== 1'b1 || write_reg_in !== 5'd12)
            $display("FAIL pp_pop12: got we=%b addr=%0d want 1 12", RegWrite, write_reg_in);
        else passed++;
        checks++; if (busy_mask !== 32'h0000_2000) $display("FAIL pp_busy13: got %h want 00002000", busy_mask); else passed++;
        step();
        checks++; if (RegWrite !== 1'b1 || write_reg_in !== 5'd13 || write_data_in !== 32'hC13)
            $display("FAIL pp_pop13: got we=%b addr=%0d data=%h want 1 13 c13", RegWrite, write_reg_in, write_data_in);
        else passed++;
        step();
    endtask

    task automatic test_addr_zero();
        r0_valid = 1'b1; r0_addr = 5'd0; r0_data = 32'h55;
        #1;
        checks++; if (r0_ready !== 1'b1) $display("FAIL z_r0_ready: got %b want 1", r0_ready); else passed++;
        step();
        r0_valid = 1'b0;
        checks++; if (RegWrite !== 1'b0) $display("FAIL z_r0_we: got %b want 0", RegWrite); else passed++;
        checks++; if (write_reg_in !== 5'd0) $display("FAIL z_r0_addr: got %0d want 0", write_reg_in); else passed++;
        r1_valid = 1'b1; r1_addr = 5'd0; r1_data = 32'h66;
        step();
        r1_valid = 1'b0;
        #1;
        checks++; if (q_count !== 2'd1 || busy_mask !== 32'd0)
            $display("FAIL z_r1_queued: got q=%0d busy=%h want q=1 busy=0", q_count, busy_mask);
        else passed++;
        step();
        checks++; if (RegWrite !== 1'b0 || q_count !== 2'd0)
            $display("FAIL z_r1_pop: got we=%b q=%0d want we=0 q=0", RegWrite, q_count);
        else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        r0_valid = 1'b1; r0_addr = 5'd2; r0_data = 32'h202;
        r1_valid = 1'b1; r1_addr = 5'd21; r1_data = 32'h2121;
        step();
        r1_addr = 5'd22; r1_data = 32'h2222;
        step();
        r0_valid = 1'b0; r1_valid = 1'b0;
        #1;
        checks++; if (q_count !== 2'd2) $display("FAIL rm_q2: got %0d want 2", q_count); else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (q_count !== 2'd0 || RegWrite !== 1'b0 || busy_mask !== 32'd0 || write_reg_in !== 5'd0)
            $display("FAIL rm_after: got q=%0d we=%b busy=%h addr=%0d want 0 0 0 0", q_count, RegWrite, busy_mask, write_reg_in);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (RegWrite !== 1'b0) $display("FAIL rm_quiet%0d: got we=%b addr=%0d want we=0", k, RegWrite, write_reg_in); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_r0_solo();
        test_r1_solo();
        test_starvation();
        test_fifo_full();
        test_push_pop();
        test_addr_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
